uart_alu_interface: RTL and testbench

Sequencer between the UART receiver and the ALU, and between the ALU and the UART transmitter. It collects three received bytes in order: operand A, operand B, then opcode. It holds them as stable ALU inputs and captures the ALU result. It then hands the result to the transmitter and waits for transmission to finish before accepting a new frame.

---
 rtl/uart_alu_interface.sv | 127 ++++++++++++
 tb/tb_uart_alu_interface.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_interface.sv
// Sequencer between UART RX, ALU and UART TX: collects operand A, operand B and
// opcode, presents them to the ALU, then sends the result and waits for TX done.
module uart_alu_interface #(
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned NB_OP   = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_reg_a,
   output logic [NB_DATA-1:0] o_reg_b,
   output logic [NB_OP-1:0]   o_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_overrun
);

   typedef enum logic [2:0] {
      ST_GET_A,
      ST_GET_B,
      ST_GET_OP,
      ST_LOAD,
      ST_WAIT_TX
   } state_t;

   state_t             r_state,    w_state_next;
   logic [NB_DATA-1:0] r_reg_a,    w_reg_a_next;
   logic [NB_DATA-1:0] r_reg_b,    w_reg_b_next;
   logic [NB_OP-1:0]   r_op,       w_op_next;
   logic [NB_DATA-1:0] r_tx_data,  w_tx_data_next;
   logic               r_tx_start, w_tx_start_next;
   logic               r_busy,     w_busy_next;
   logic               r_overrun,  w_overrun_next;

   // State and output registers; reset wins over everything, discarding partial frames
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_GET_A;
         r_reg_a    <= '0;
         r_reg_b    <= '0;
         r_op       <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_reg_a    <= w_reg_a_next;
         r_reg_b    <= w_reg_b_next;
         r_op       <= w_op_next;
         r_tx_data  <= w_tx_data_next;
         r_tx_start <= w_tx_start_next;
         r_busy     <= w_busy_next;
         r_overrun  <= w_overrun_next;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_next    = r_state;
      w_reg_a_next    = r_reg_a;
      w_reg_b_next    = r_reg_b;
      w_op_next       = r_op;
      w_tx_data_next  = r_tx_data;
      w_tx_start_next = 1'b0;
      w_overrun_next  = r_overrun;

      case (r_state)
         ST_GET_A: begin
            if (i_rx_done) begin
               w_reg_a_next = i_rx_data;
               w_state_next = ST_GET_B;
            end
         end
         ST_GET_B: begin
            if (i_rx_done) begin
               w_reg_b_next = i_rx_data;
               w_state_next = ST_GET_OP;
            end
         end
         ST_GET_OP: begin
            if (i_rx_done) begin
               w_op_next    = i_rx_data[NB_OP-1:0];
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // ALU has had one cycle to settle on the new opcode
            w_tx_data_next  = i_alu_result;
            w_tx_start_next = 1'b1;
            w_state_next    = ST_WAIT_TX;
            if (i_rx_done) begin
               w_overrun_next = 1'b1;
            end
         end
         ST_WAIT_TX: begin
            if (i_tx_done && i_rx_done) begin
               w_reg_a_next = i_rx_data;
               w_state_next = ST_GET_B;
            end else if (i_tx_done) begin
               w_state_next = ST_GET_A;
            end else if (i_rx_done) begin
               w_overrun_next = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_GET_A;
         end
      endcase

      // Registered busy tracks the state being entered, so it matches the state exactly
      w_busy_next = (w_state_next == ST_LOAD) || (w_state_next == ST_WAIT_TX);
   end

   assign o_reg_a    = r_reg_a;
   assign o_reg_b    = r_reg_b;
   assign o_op       = r_op;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = r_tx_start;
   assign o_busy     = r_busy;
   assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a small behavioural ALU on its outputs.
module tb_uart_alu_interface;

   localparam int unsigned NB_DATA = 8;
   localparam int unsigned NB_OP   = 6;

   logic               clk = 1'b0;
   logic               rst;
   logic [NB_DATA-1:0] rx_data;
   logic               rx_done;
   logic [NB_DATA-1:0] alu_result;
   logic               tx_done;
   logic [NB_DATA-1:0] reg_a;
   logic [NB_DATA-1:0] reg_b;
   logic [NB_OP-1:0]   op;
   logic [NB_DATA-1:0] tx_data;
   logic               tx_start;
   logic               busy;
   logic               overrun;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   uart_alu_interface #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .i_alu_result (alu_result),
      .i_tx_done    (tx_done),
      .o_reg_a      (reg_a),
      .o_reg_b      (reg_b),
      .o_op         (op),
      .o_tx_data    (tx_data),
      .o_tx_start   (tx_start),
      .o_busy       (busy),
      .o_overrun    (overrun)
   );

   // Behavioural ALU driven from the registered operands
   always_comb begin
      case (op)
         6'h20:   alu_result = reg_a + reg_b;
         6'h22:   alu_result = reg_a - reg_b;
         6'h24:   alu_result = reg_a & reg_b;
         6'h25:   alu_result = reg_a | reg_b;
         6'h26:   alu_result = reg_a ^ reg_b;
         default: alu_result = '0;
      endcase
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op_byte;
      logic [5:0] exp_op;
      logic [7:0] exp_res;
   } frame_t;

   frame_t frames [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic pulse_rx(input logic [7:0] d);
      @(negedge clk);
      rx_data = d;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " reg_a"},    32'(reg_a),    32'h0);
      check({tag, " reg_b"},    32'(reg_b),    32'h0);
      check({tag, " op"},       32'(op),       32'h0);
      check({tag, " tx_data"},  32'(tx_data),  32'h0);
      check({tag, " tx_start"}, 32'(tx_start), 32'h0);
      check({tag, " busy"},     32'(busy),     32'h0);
      check({tag, " overrun"},  32'(overrun),  32'h0);
   endtask

   // Full frame with exact tx_start timing; optionally completes the transmission
   task automatic run_frame(input frame_t f, input bit finish_tx);
      pulse_rx(f.a);
      pulse_rx(f.b);
      check("frame reg_a", 32'(reg_a), 32'(f.a));
      check("frame reg_b", 32'(reg_b), 32'(f.b));
      check("frame busy while collecting", 32'(busy), 32'h0);
      pulse_rx(f.op_byte);
      check("frame op", 32'(op), 32'(f.exp_op));
      check("frame busy in load", 32'(busy), 32'h1);
      check("frame no early tx_start", 32'(tx_start), 32'h0);
      @(negedge clk);
      check("frame tx_start", 32'(tx_start), 32'h1);
      check("frame tx_data", 32'(tx_data), 32'(f.exp_res));
      @(negedge clk);
      check("frame tx_start one cycle", 32'(tx_start), 32'h0);
      check("frame busy in wait", 32'(busy), 32'h1);
      if (finish_tx) begin
         pulse_tx_done();
         check("frame idle after tx_done", 32'(busy), 32'h0);
         check("frame reg_a held", 32'(reg_a), 32'(f.a));
         check("frame tx_data held", 32'(tx_data), 32'(f.exp_res));
      end
   endtask

   initial begin
      frame_t f;
      frames[0] = '{a: 8'h03, b: 8'h0C, op_byte: 8'h20, exp_op: 6'h20, exp_res: 8'h0F};
      frames[1] = '{a: 8'h05, b: 8'h07, op_byte: 8'hE2, exp_op: 6'h22, exp_res: 8'hFE};
      frames[2] = '{a: 8'hF3, b: 8'h3C, op_byte: 8'h24, exp_op: 6'h24, exp_res: 8'h30};
      frames[3] = '{a: 8'hAA, b: 8'h0F, op_byte: 8'h66, exp_op: 6'h26, exp_res: 8'hA5};

      rst     = 1'b1;
      rx_data = '0;
      rx_done = 1'b0;
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_frame(frames[i], 1'b1);

      // Byte during WAIT_TX is dropped and sets the sticky overrun
      run_frame(frames[1], 1'b0);
      pulse_rx(8'h55);
      check("overrun set in wait", 32'(overrun), 32'h1);
      check("overrun byte dropped", 32'(reg_a), 32'h05);
      check("overrun still busy", 32'(busy), 32'h1);
      pulse_tx_done();
      f = '{a: 8'hF0, b: 8'h0F, op_byte: 8'h25, exp_op: 6'h25, exp_res: 8'hFF};
      run_frame(f, 1'b1);
      check("overrun sticky", 32'(overrun), 32'h1);

      do_reset();
      check_all_zero("reset clears overrun");

      // Coincident tx_done and rx_done: byte becomes operand A
      f = '{a: 8'h11, b: 8'h22, op_byte: 8'h20, exp_op: 6'h20, exp_res: 8'h33};
      run_frame(f, 1'b0);
      @(negedge clk);
      rx_data = 8'h09;
      rx_done = 1'b1;
      tx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      tx_done = 1'b0;
      check("simul reg_a", 32'(reg_a), 32'h09);
      check("simul busy", 32'(busy), 32'h0);
      check("simul overrun", 32'(overrun), 32'h0);
      pulse_rx(8'h01);
      check("simul next is reg_b", 32'(reg_b), 32'h01);
      check("simul reg_a kept", 32'(reg_a), 32'h09);
      pulse_rx(8'h20);
      check("simul op", 32'(op), 32'h20);
      @(negedge clk);
      check("simul tx_start", 32'(tx_start), 32'h1);
      check("simul tx_data", 32'(tx_data), 32'h0A);
      pulse_tx_done();

      // Byte arriving in the LOAD settle cycle is an overrun; send still happens
      pulse_rx(8'h02);
      pulse_rx(8'h03);
      @(negedge clk);
      rx_data = 8'h20;
      rx_done = 1'b1;
      @(negedge clk);
      rx_data = 8'h77;
      check("load op", 32'(op), 32'h20);
      @(negedge clk);
      rx_done = 1'b0;
      check("load overrun", 32'(overrun), 32'h1);
      check("load tx_start", 32'(tx_start), 32'h1);
      check("load tx_data", 32'(tx_data), 32'h05);
      check("load reg_a kept", 32'(reg_a), 32'h02);
      pulse_tx_done();
      check("load idle", 32'(busy), 32'h0);

      // Reset mid-frame discards the partial frame
      pulse_rx(8'hAA);
      pulse_rx(8'hBB);
      do_reset();
      check_all_zero("midframe reset");
      pulse_tx_done();
      check("tx_done ignored busy", 32'(busy), 32'h0);
      check("tx_done ignored tx_start", 32'(tx_start), 32'h0);
      f = '{a: 8'h01, b: 8'h01, op_byte: 8'h20, exp_op: 6'h20, exp_res: 8'h02};
      run_frame(f, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
